// File: rtl/pipe_stage_skid_if.sv
// Handshake and status bundle for pipe_stage_skid; the slave modport is the stage's view.
interface pipe_stage_skid_if #(
    parameter int INSTR_W = 8,
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 16
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               in_regwrite;
    logic               in_loadimm;
    logic [DATA_W-1:0]  in_alures;
    logic [DATA_W-1:0]  in_immdata;
    logic [REG_AW-1:0]  in_writereg;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic               out_regwrite;
    logic               out_loadimm;
    logic [DATA_W-1:0]  out_alures;
    logic [DATA_W-1:0]  out_immdata;
    logic [REG_AW-1:0]  out_writereg;
    logic [1:0]         occupancy;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport slave (
        input  flush, in_valid, in_instr, in_regwrite, in_loadimm, in_alures,
               in_immdata, in_writereg, out_ready,
        output in_ready, out_valid, out_instr, out_regwrite, out_loadimm,
               out_alures, out_immdata, out_writereg, occupancy, stall_cnt, flush_cnt
    );

    modport master (
        output flush, in_valid, in_instr, in_regwrite, in_loadimm, in_alures,
               in_immdata, in_writereg, out_ready,
        input  in_ready, out_valid, out_instr, out_regwrite, out_loadimm,
               out_alures, out_immdata, out_writereg, occupancy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// 2-entry skid-buffered pipeline stage (main + skid register), all outputs registered.
// Optional stall/flush performance counters enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int INSTR_W = 8,
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_skid_if.slave  bus
);

    typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               regwrite;
        logic               loadimm;
        logic [DATA_W-1:0]  alures;
        logic [DATA_W-1:0]  immdata;
        logic [REG_AW-1:0]  writereg;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, in_e;
    logic   in_rdy, out_vld, accept, emit;

    assign in_e = '{instr:    bus.in_instr,
                    regwrite: bus.in_regwrite,
                    loadimm:  bus.in_loadimm,
                    alures:   bus.in_alures,
                    immdata:  bus.in_immdata,
                    writereg: bus.in_writereg};

    // Handshake decoded from registered state only: no combinational in->out path.
    assign in_rdy  = (state_q != FULL);
    assign out_vld = (state_q != EMPTY);
    assign accept  = bus.in_valid & in_rdy;
    assign emit    = out_vld & bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = HALF;
                        main_d  = in_e;
                    end
                end
                HALF: begin
                    if (accept && emit) begin
                        main_d = in_e;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_e;
                    end else if (emit) begin
                        // Clearing keeps regwrite/loadimm low whenever out_valid is low.
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_d = HALF;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = out_vld;
    assign bus.out_instr    = main_q.instr;
    assign bus.out_regwrite = main_q.regwrite;
    assign bus.out_loadimm  = main_q.loadimm;
    assign bus.out_alures   = main_q.alures;
    assign bus.out_immdata  = main_q.immdata;
    assign bus.out_writereg = main_q.writereg;
    assign bus.occupancy    = 2'(state_q);

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Both counters saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_vld && !bus.out_ready && !bus.flush && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (bus.flush && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: narrow build plus a wide-payload build.
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.INSTR_W(8), .DATA_W(8),  .REG_AW(3), .CNT_W(4)) bus ();
    pipe_stage_skid_if #(.INSTR_W(8), .DATA_W(16), .REG_AW(5), .CNT_W(4)) wbus ();

    pipe_stage_skid #(.INSTR_W(8), .DATA_W(8), .REG_AW(3), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_stage_skid #(.INSTR_W(8), .DATA_W(16), .REG_AW(5), .CNT_W(4)) u_wide (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] instr);
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_regwrite = 1'b1;
        bus.in_loadimm  = instr[0];
        bus.in_alures   = instr + 8'd1;
        bus.in_immdata  = ~instr;
        bus.in_writereg = instr[2:0];
    endtask

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.in_instr = 0; bus.in_regwrite = 0;
        bus.in_loadimm = 0; bus.in_alures = 0; bus.in_immdata = 0; bus.in_writereg = 0;
        bus.out_ready = 0;
        wbus.flush = 0; wbus.in_valid = 0; wbus.in_instr = 0; wbus.in_regwrite = 0;
        wbus.in_loadimm = 0; wbus.in_alures = 0; wbus.in_immdata = 0; wbus.in_writereg = 0;
        wbus.out_ready = 0;

        // reset state
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_occ",       32'(bus.occupancy), 0);
        chk("rst_in_ready",  32'(bus.in_ready),  1);
        chk("rst_out_instr", 32'(bus.out_instr), 0);
        chk("rst_stall",     32'(bus.stall_cnt), 0);
        chk("rst_flushcnt",  32'(bus.flush_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // streaming at full throughput
        bus.out_ready = 1'b1;
        send(8'h11); tick();
        chk("s1_instr",  32'(bus.out_instr),  32'h11);
        chk("s1_alures", 32'(bus.out_alures), 32'h12);
        chk("s1_occ",    32'(bus.occupancy),  1);
        chk("s1_rdy",    32'(bus.in_ready),   1);
        send(8'h22); tick();
        chk("s2_instr",  32'(bus.out_instr),  32'h22);
        chk("s2_occ",    32'(bus.occupancy),  1);
        send(8'h33); tick();
        chk("s3_instr",  32'(bus.out_instr),  32'h33);
        chk("s3_imm",    32'(bus.out_immdata), 32'hCC);
        chk("s3_rdy",    32'(bus.in_ready),   1);
        bus.in_valid = 1'b0; tick();
        chk("s_drain_valid", 32'(bus.out_valid),    0);
        chk("s_drain_rw",    32'(bus.out_regwrite), 0);
        chk("s_drain_instr", 32'(bus.out_instr),    0);

        // backpressure fills the skid register
        bus.out_ready = 1'b0;
        send(8'hA1); tick();
        chk("bp1_occ",   32'(bus.occupancy), 1);
        chk("bp1_instr", 32'(bus.out_instr), 32'hA1);
        send(8'hA2); tick();
        chk("bp2_occ",   32'(bus.occupancy), 2);
        chk("bp2_rdy",   32'(bus.in_ready),  0);
        chk("bp2_instr", 32'(bus.out_instr), 32'hA1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; tick();
        chk("bp3_instr", 32'(bus.out_instr), 32'hA2);
        chk("bp3_rdy",   32'(bus.in_ready),  1);
        chk("bp3_occ",   32'(bus.occupancy), 1);
        tick();
        chk("bp4_valid", 32'(bus.out_valid), 0);
        chk("bp_stall",  32'(bus.stall_cnt), PERF ? 32'd1 : 32'd0);

        // flush while FULL with an upstream entry offered
        bus.out_ready = 1'b0;
        send(8'hC1); tick();
        send(8'hC2); tick();
        chk("fl_pre_occ", 32'(bus.occupancy), 2);
        send(8'hB3); bus.flush = 1'b1; tick();
        chk("fl_valid", 32'(bus.out_valid),    0);
        chk("fl_rw",    32'(bus.out_regwrite), 0);
        chk("fl_occ",   32'(bus.occupancy),    0);
        chk("fl_rdy",   32'(bus.in_ready),     1);
        chk("fl_cnt",   32'(bus.flush_cnt), PERF ? 32'd1 : 32'd0);
        chk("fl_stall", 32'(bus.stall_cnt), PERF ? 32'd2 : 32'd0);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; tick();
        chk("fl_post_valid", 32'(bus.out_valid), 0);
        chk("fl_post_instr", 32'(bus.out_instr), 0);

        // asynchronous reset between edges while FULL
        bus.out_ready = 1'b0;
        send(8'hE1); tick();
        send(8'hE2); tick();
        bus.in_valid = 1'b0;
        chk("ar_pre_occ", 32'(bus.occupancy), 2);
        #2 rst = 1'b0;
        #1;
        chk("ar_occ",   32'(bus.occupancy), 0);
        chk("ar_valid", 32'(bus.out_valid), 0);
        chk("ar_instr", 32'(bus.out_instr), 0);
        chk("ar_rw",    32'(bus.out_regwrite), 0);
        chk("ar_rdy",   32'(bus.in_ready),  1);
        chk("ar_stall", 32'(bus.stall_cnt), 0);
        chk("ar_fcnt",  32'(bus.flush_cnt), 0);
        #1 rst = 1'b1;
        bus.out_ready = 1'b1;
        send(8'hF1); tick();
        chk("ar_post_instr", 32'(bus.out_instr), 32'hF1);
        chk("ar_post_occ",   32'(bus.occupancy), 1);
        bus.in_valid = 1'b0; tick();
        chk("ar_post_empty", 32'(bus.out_valid), 0);

        // counter saturation and flush counting
        bus.out_ready = 1'b0;
        send(8'hD1); tick();
        bus.in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_stall", 32'(bus.stall_cnt), PERF ? 32'd15 : 32'd0);
        chk("sat_occ",   32'(bus.occupancy), 1);
        bus.flush = 1'b1; tick();
        bus.flush = 1'b0; tick();
        bus.flush = 1'b1; tick();
        bus.flush = 1'b0; tick();
        chk("cnt_flush", 32'(bus.flush_cnt), PERF ? 32'd2 : 32'd0);
        chk("cnt_stall_hold", 32'(bus.stall_cnt), PERF ? 32'd15 : 32'd0);

        // wide payload fidelity
        wbus.out_ready   = 1'b1;
        wbus.in_valid    = 1'b1;
        wbus.in_instr    = 8'h5A;
        wbus.in_alures   = 16'hBEEF;
        wbus.in_immdata  = 16'h1234;
        wbus.in_writereg = 5'd31;
        wbus.in_regwrite = 1'b1;
        wbus.in_loadimm  = 1'b1;
        tick();
        wbus.in_valid = 1'b0;
        chk("w_valid",  32'(wbus.out_valid),    1);
        chk("w_instr",  32'(wbus.out_instr),    32'h5A);
        chk("w_alures", 32'(wbus.out_alures),   32'hBEEF);
        chk("w_imm",    32'(wbus.out_immdata),  32'h1234);
        chk("w_wreg",   32'(wbus.out_writereg), 32'd31);
        chk("w_rw",     32'(wbus.out_regwrite), 1);
        chk("w_li",     32'(wbus.out_loadimm),  1);
        tick();
        chk("w_empty_valid", 32'(wbus.out_valid),   0);
        chk("w_empty_li",    32'(wbus.out_loadimm), 0);
        chk("w_empty_alu",   32'(wbus.out_alures),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
